hack_io_hub: RTL and testbench
==============================

Name: hack_io_hub

Overview:
Parametrised memory-mapped I/O block for the Hack SoC. It replaces the fixed keyboard, GPIO_I and GPIO_O decode with a relocatable window that provides:
- NUM_GPIO input/output port pairs;
- a synchronised keyboard path with a small key FIFO, so keystrokes are not lost between polls;
- a status register.

It sits beside the RAM/VRAM encoders. hack_soc muxes its read data into the CPU inM whenever io_hit is high.

Parameters:
- WORD_WIDTH, 16, Hack data word width.
- ADDR_WIDTH, 15, Hack addressM width.
- BASE_ADDR, 15'h6000, first address of the I/O window (keyboard register).
- NUM_GPIO, 2, number of GPIO in/out port pairs (1..8).
- GPIO_WIDTH, 8, bits per GPIO port (1..WORD_WIDTH).
- KEY_FIFO_DEPTH, 4, key FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- hack_clk_rise  in  1  one-clk strobe at the Hack CPU commit edge; all CPU-visible state updates only here
- hack_reset  in  1  level; while high, CPU writes and pops are ignored and gpio_o is cleared
- addressM  in  ADDR_WIDTH  CPU address
- writeM  in  1  CPU write enable
- outM  in  WORD_WIDTH  CPU write data
- io_hit  out  1  combinational; addressM is inside the window BASE_ADDR..BASE_ADDR+1+2*NUM_GPIO
- io_rdata  out  WORD_WIDTH  combinational read data for addressM; 0 when io_hit=0
- keycode  in  8  raw keyboard code (asynchronous)
- key_strobe  in  1  asynchronous level; each rising edge marks a new keycode
- gpio_i  in  NUM_GPIO*GPIO_WIDTH  raw inputs, port k at bits [k*GPIO_WIDTH +: GPIO_WIDTH]
- gpio_o  out  NUM_GPIO*GPIO_WIDTH  registered outputs
- key_overflow  out  1  sticky overflow flag, same value as status bit1

Behaviour:
Address map, offset from BASE_ADDR:
- 0: KBD. Read only; writes are ignored.
- 1: STATUS, with fields:
  - bit0 = FIFO not empty;
  - bit1 = overflow (sticky);
  - bits[6:2] = FIFO count;
  - other bits read 0.
  - A write with outM[1]=1 clears the overflow flag. All other bits are read-only.
- 2+2k: GPIO_I port k. Read only; returns the synchronised value, zero-extended.
- 3+2k: GPIO_O port k. Read/write; reads return the current gpio_o slice, zero-extended.

Synchronisers:
- gpio_i passes through 2-FF synchronisers on clk.
- key_strobe passes through a 3-FF chain; a push event is the rising edge of stages 2/3.
- keycode is captured into a holding register when stage 1 rises. keycode must be stable for 2 clk before key_strobe rises.
- A push whose captured keycode is 0 is discarded (no push, no overflow).

Commit rules (only when hack_clk_rise=1 and hack_reset=0):
- Write to GPIO_O k: the slice takes outM[GPIO_WIDTH-1:0] on the next clk.
- Read of KBD (writeM=0) with FIFO not empty: pop the head. io_rdata already presented the head during the cycle, so the CPU sees the popped value.
- A write to KBD does not pop.

Key FIFO:
- Circular buffer with head/tail pointers of log2(DEPTH) bits, wrapping at DEPTH, and a count of log2(DEPTH)+1 bits.
- Empty: KBD reads 0; a pop request is ignored.
- Full, push only: the key is dropped, contents are unchanged, overflow is set.
- Push and pop in the same clk: both take effect and count is unchanged. This also applies when full, in which case there is no overflow.
- Overflow clear and a new overflow in the same clk: set wins.

Reset and hack_reset:
- reset clears all of: FIFO and pointers, count, overflow, gpio_o, synchronisers, holding register. After reset, io_rdata is 0 for every address.
- hack_reset=1 clears gpio_o only. FIFO and overflow keep their contents and pushes still occur.

Latency:
- gpio_i pin to GPIO_I read: 2–3 clk.
- key_strobe rise to FIFO visible: 3–4 clk.
- GPIO_O write: 1 clk after the commit strobe.

Optional Feature:
Macro HACK_IO_KEY_FIFO_EN.
- Defined: key FIFO behaviour exactly as described above.
- Undefined:
  - No FIFO is built.
  - KBD returns the synchronised holding register while the synchronised key_strobe is high, and 0 otherwise (classic Hack level semantics).
  - Reads never pop.
  - STATUS bit0 = synchronised strobe level; bit1 and the count field read 0; key_overflow is tied to 0.
  - The KEY_FIFO_DEPTH parameter is ignored.

Test Plan:
- Apply reset, then read every offset 0..5 (NUM_GPIO=2) -> io_rdata=0 and gpio_o=0; io_hit=1 for 0x6000..0x6005 and io_hit=0 for 0x5FFF and 0x6006.
- Write 0x00A5 to 0x6003 on hack_clk_rise -> gpio_o[7:0]=0xA5 one clk later; reading 0x6003 returns 0x00A5; assert hack_reset -> gpio_o=0.
- Drive gpio_i port1=0x3C and wait 3 clk -> reading 0x6004 returns 0x003C; a change held only 1 clk less than the synchroniser depth must not appear before 2 clk.
- FIFO on, DEPTH=4: push keys 0x41,0x42,0x43,0x44,0x45 -> STATUS=0x0013 (count 4, not empty, overflow); KBD reads pop 0x41..0x44, then 0x0000; write 0x0002 to STATUS -> overflow clears.
- FIFO on, full: a push and a KBD pop in the same clk -> count stays 4, no overflow, new key becomes the tail; push of keycode 0 -> ignored.
- FIFO off: hold key_strobe with keycode 0x20 -> KBD reads 0x0020 repeatedly with no pop; release -> 0x0000 within 3 clk.

Source files
------------

// File: rtl/hack_io_hub.sv
// hack_io_hub: relocatable memory-mapped I/O window for the Hack SoC.
// Offsets from BASE_ADDR: 0 KBD, 1 STATUS, 2+2k GPIO_I port k, 3+2k GPIO_O port k.
// Optional build macro HACK_IO_KEY_FIFO_EN: when defined, keystrokes are
// queued in a KEY_FIFO_DEPTH-entry FIFO that KBD reads pop; when undefined,
// KBD shows the classic Hack level (key code while the key is held, else 0).
// CPU access qualifier: an access on addressM/writeM/outM takes effect only on
// a clk where hack_clk_rise=1 and hack_reset=0; reads are combinational and
// side-effect free except a KBD read committed with a non-empty FIFO, which pops.
module hack_io_hub #(
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_WIDTH = 15,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h6000,
    parameter int NUM_GPIO = 2,
    parameter int GPIO_WIDTH = 8,
    parameter int KEY_FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           hack_clk_rise,
    input  logic                           hack_reset,
    input  logic [ADDR_WIDTH-1:0]          addressM,
    input  logic                           writeM,
    input  logic [WORD_WIDTH-1:0]          outM,
    output logic                           io_hit,
    output logic [WORD_WIDTH-1:0]          io_rdata,
    input  logic [7:0]                     keycode,
    input  logic                           key_strobe,
    input  logic [NUM_GPIO*GPIO_WIDTH-1:0] gpio_i,
    output logic [NUM_GPIO*GPIO_WIDTH-1:0] gpio_o,
    output logic                           key_overflow
);

    localparam int NUM_REGS = 2 + 2 * NUM_GPIO;
    localparam int GW = NUM_GPIO * GPIO_WIDTH;

    logic [ADDR_WIDTH-1:0] offset;
    logic                  commit;
    logic                  kbd_sel;
    logic                  stat_sel;
    logic [GW-1:0]         gpio_s1;
    logic [GW-1:0]         gpio_s2;
    logic [2:0]            ks;        // ks[0]=stage1, ks[1]=stage2, ks[2]=stage3
    logic [7:0]            key_hold;
    logic [7:0]            kbd_data;
    logic [6:0]            status_low;
    logic                  unused_outm;

    assign offset   = addressM - BASE_ADDR;
    assign io_hit   = (addressM >= BASE_ADDR) && (offset < ADDR_WIDTH'(NUM_REGS));
    assign commit   = hack_clk_rise & ~hack_reset;
    assign kbd_sel  = io_hit && (offset == '0);
    assign stat_sel = io_hit && (offset == ADDR_WIDTH'(1));
    // Only the low GPIO_WIDTH bits and bit1 of outM carry meaning here.
    assign unused_outm = ^outM;

    // Input synchronisers and keycode holding register (captured as stage1 rises).
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_s1  <= '0;
            gpio_s2  <= '0;
            ks       <= '0;
            key_hold <= '0;
        end else begin
            gpio_s1 <= gpio_i;
            gpio_s2 <= gpio_s1;
            ks      <= {ks[1:0], key_strobe};
            if (ks[0] && !ks[1]) begin
                key_hold <= keycode;
            end
        end
    end

    // GPIO output ports: written by committed CPU stores, cleared by hack_reset.
    always_ff @(posedge clk) begin
        if (reset || hack_reset) begin
            gpio_o <= '0;
        end else if (commit && writeM && io_hit) begin
            for (int k = 0; k < NUM_GPIO; k++) begin
                if (offset == ADDR_WIDTH'(3 + 2 * k)) begin
                    gpio_o[k*GPIO_WIDTH +: GPIO_WIDTH] <= outM[GPIO_WIDTH-1:0];
                end
            end
        end
    end

`ifdef HACK_IO_KEY_FIFO_EN
    localparam int PW = $clog2(KEY_FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    fifo_mem [KEY_FIFO_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          overflow;
    logic          fifo_empty;
    logic          fifo_full;
    logic          key_push;
    logic          pop;
    logic          ovf_clear;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(KEY_FIFO_DEPTH));
    // A zero keycode is not a keystroke and never reaches the FIFO.
    assign key_push   = ks[1] && !ks[2] && (key_hold != 8'h00);
    assign pop        = commit && kbd_sel && !writeM && !fifo_empty;
    assign ovf_clear  = commit && stat_sel && writeM && outM[1];

    // Key FIFO: push from the strobe path, pop on committed KBD reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < KEY_FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // When full, a simultaneous pop frees the head slot, which is the tail slot.
            if (key_push && (!fifo_full || pop)) begin
                fifo_mem[tail] <= key_hold;
                tail           <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            if (key_push && !pop && !fifo_full) begin
                count <= count + CW'(1);
            end else if (pop && !key_push) begin
                count <= count - CW'(1);
            end
            // A fresh overflow beats a clear in the same cycle.
            if (key_push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    assign kbd_data     = fifo_empty ? 8'h00 : fifo_mem[head];
    assign status_low   = {5'(count), overflow, !fifo_empty};
    assign key_overflow = overflow;
`else
    // Classic level semantics: the held code is visible while the key is down.
    assign kbd_data     = ks[2] ? key_hold : 8'h00;
    assign status_low   = {6'b0, ks[2]};
    assign key_overflow = 1'b0;
`endif

    // Read data mux; zero outside the window and for unmapped bits.
    always_comb begin
        io_rdata = '0;
        if (io_hit) begin
            if (offset == '0) begin
                io_rdata = {{(WORD_WIDTH-8){1'b0}}, kbd_data};
            end
            if (offset == ADDR_WIDTH'(1)) begin
                io_rdata = {{(WORD_WIDTH-7){1'b0}}, status_low};
            end
            for (int k = 0; k < NUM_GPIO; k++) begin
                if (offset == ADDR_WIDTH'(2 + 2 * k)) begin
                    io_rdata[GPIO_WIDTH-1:0] = gpio_s2[k*GPIO_WIDTH +: GPIO_WIDTH];
                end
                if (offset == ADDR_WIDTH'(3 + 2 * k)) begin
                    io_rdata[GPIO_WIDTH-1:0] = gpio_o[k*GPIO_WIDTH +: GPIO_WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_hack_io_hub.sv
// tb_hack_io_hub: directed and random stimulus for hack_io_hub (default
// parameters) checked every cycle against a behavioural model. Build with or
// without HACK_IO_KEY_FIFO_EN; the model follows the same macro.
module tb_hack_io_hub;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        hack_clk_rise;
    logic        hack_reset;
    logic [14:0] addressM;
    logic        writeM;
    logic [15:0] outM;
    logic        io_hit;
    logic [15:0] io_rdata;
    logic [7:0]  keycode;
    logic        key_strobe;
    logic [15:0] gpio_i;
    logic [15:0] gpio_o;
    logic        key_overflow;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 0;

    hack_io_hub dut (
        .clk(clk), .reset(reset), .hack_clk_rise(hack_clk_rise),
        .hack_reset(hack_reset), .addressM(addressM), .writeM(writeM),
        .outM(outM), .io_hit(io_hit), .io_rdata(io_rdata), .keycode(keycode),
        .key_strobe(key_strobe), .gpio_i(gpio_i), .gpio_o(gpio_o),
        .key_overflow(key_overflow)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Pin samples are kept as short delay lines: index 0 is the newest sample.
    logic [3:0]  m_sh;          // key_strobe samples
    logic [7:0]  m_kh [2];      // keycode samples
    logic [15:0] m_gh [2];      // gpio_i samples
    logic [7:0]  m_kq [$];      // key FIFO contents, head first
    logic        m_ovf;
    logic [7:0]  m_hold;
    logic [7:0]  m_gpo [2];
    logic [7:0]  m_dummy;

    function automatic bit in_win(input logic [14:0] a);
        return (a >= 15'h6000) && (a <= 15'h6005);
    endfunction

    function automatic logic [15:0] exp_rdata(input logic [14:0] a);
        int off;
        if (!in_win(a)) return 16'h0000;
        off = int'(a) - 'h6000;
        if (off == 0) begin
`ifdef HACK_IO_KEY_FIFO_EN
            return (m_kq.size() > 0) ? {8'h00, m_kq[0]} : 16'h0000;
`else
            return m_sh[2] ? {8'h00, m_hold} : 16'h0000;
`endif
        end
        if (off == 1) begin
`ifdef HACK_IO_KEY_FIFO_EN
            return 16'((m_kq.size() << 2) | (int'(m_ovf) << 1) | int'(m_kq.size() > 0));
`else
            return {15'h0, m_sh[2]};
`endif
        end
        if (off % 2 == 0) return {8'h00, m_gh[1][((off - 2) / 2) * 8 +: 8]};
        return {8'h00, m_gpo[(off - 3) / 2]};
    endfunction

    always @(posedge clk) begin
        int  off;
        bit  commit, hit, pop, push;
        if (reset) begin
            m_sh = '0; m_kh[0] = '0; m_kh[1] = '0; m_gh[0] = '0; m_gh[1] = '0;
            m_kq.delete(); m_ovf = 1'b0; m_hold = '0; m_gpo[0] = '0; m_gpo[1] = '0;
        end else begin
            hit    = in_win(addressM);
            off    = int'(addressM) - 'h6000;
            commit = hack_clk_rise && !hack_reset;
            m_sh    = {m_sh[2:0], key_strobe};
            m_kh[1] = m_kh[0]; m_kh[0] = keycode;
            m_gh[1] = m_gh[0]; m_gh[0] = gpio_i;
            // A strobe rise first sampled two edges ago completes now.
            push = m_sh[2] && !m_sh[3];
            if (push) m_hold = m_kh[1];
`ifdef HACK_IO_KEY_FIFO_EN
            push = push && (m_kh[1] != 8'h00);
            pop  = commit && hit && off == 0 && !writeM && m_kq.size() > 0;
            if (push && pop) begin
                m_dummy = m_kq.pop_front(); m_kq.push_back(m_kh[1]);
            end else if (push) begin
                if (m_kq.size() == DEPTH) m_ovf = 1'b1;
                else m_kq.push_back(m_kh[1]);
            end else if (pop) begin
                m_dummy = m_kq.pop_front();
            end
            if (!(push && !pop && m_kq.size() == DEPTH && m_ovf) &&
                commit && hit && off == 1 && writeM && outM[1] &&
                !(push && !pop && m_kq.size() == DEPTH))
                m_ovf = 1'b0;
`else
            pop = 1'b0;
`endif
            if (hack_reset) begin
                m_gpo[0] = '0; m_gpo[1] = '0;
            end else if (commit && writeM && hit && off >= 3 && off % 2 == 1) begin
                m_gpo[(off - 3) / 2] = outM[7:0];
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("io_hit", {15'h0, io_hit}, {15'h0, in_win(addressM)});
            check("io_rdata", io_rdata, exp_rdata(addressM));
            check("gpio_o", gpio_o, {m_gpo[1], m_gpo[0]});
`ifdef HACK_IO_KEY_FIFO_EN
            check("key_overflow", {15'h0, key_overflow}, {15'h0, m_ovf});
`else
            check("key_overflow", {15'h0, key_overflow}, 16'h0000);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [14:0] a, input logic we, input logic [15:0] d, input logic rise);
        addressM = a; writeM = we; outM = d; hack_clk_rise = rise;
    endtask

    task automatic cpu_write(input logic [14:0] a, input logic [15:0] d);
        step(); bus(a, 1'b1, d, 1'b1);
        step(); bus(a, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic press(input logic [7:0] code);
        step(); keycode = code;
        step(); step(); key_strobe = 1'b1;
        repeat (4) step();
        key_strobe = 1'b0;
        repeat (4) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ks_cnt;
        reset = 1'b1; hack_reset = 1'b0; keycode = 8'h00; key_strobe = 1'b0;
        gpio_i = 16'h0; bus(15'h6000, 1'b0, 16'h0, 1'b0);
        repeat (3) step();
        reset = 1'b0; check_en = 1;

        // Reset state and window decode.
        for (int a = 'h5FFF; a <= 'h6006; a++) begin
            addressM = 15'(a);
            @(negedge clk);
            check("rst_hit", {15'h0, io_hit}, (a >= 'h6000 && a <= 'h6005) ? 16'h1 : 16'h0);
            check("rst_rdata", io_rdata, 16'h0000);
            check("rst_gpio_o", gpio_o, 16'h0000);
            step();
        end

        // GPIO_O write, readback, hack_reset clear.
        cpu_write(15'h6003, 16'h00A5);
        @(negedge clk);
        check("gpo_write", gpio_o, 16'h00A5);
        check("gpo_read", io_rdata, 16'h00A5);
        step(); hack_reset = 1'b1;
        step(); hack_reset = 1'b0;
        @(negedge clk);
        check("gpo_hack_reset", gpio_o, 16'h0000);

        // GPIO_I synchroniser latency.
        step(); gpio_i = 16'h3C00; addressM = 15'h6004;
        @(negedge clk); check("gpi_early0", io_rdata, 16'h0000);
        step(); @(negedge clk); check("gpi_early1", io_rdata, 16'h0000);
        step(); @(negedge clk); check("gpi_sync", io_rdata, 16'h003C);

        // Five keys into a four-entry FIFO.
        for (int i = 0; i < 5; i++) press(8'(8'h41 + i));
        addressM = 15'h6001;
        @(negedge clk);
`ifdef HACK_IO_KEY_FIFO_EN
        check("fifo_status", io_rdata, 16'h0013);
        check("model_status", exp_rdata(15'h6001), 16'h0013);
        check("fifo_ovf", {15'h0, key_overflow}, 16'h0001);
`else
        check("lvl_status", io_rdata, 16'h0000);
`endif
        for (int i = 0; i < 5; i++) begin
            step(); bus(15'h6000, 1'b0, 16'h0, 1'b1);
            @(negedge clk);
`ifdef HACK_IO_KEY_FIFO_EN
            check("fifo_pop", io_rdata, (i < 4) ? 16'(16'h41 + i) : 16'h0000);
`else
            check("lvl_kbd_idle", io_rdata, 16'h0000);
`endif
            step(); hack_clk_rise = 1'b0;
        end
        cpu_write(15'h6001, 16'h0002);
        @(negedge clk);
        check("ovf_clear", {15'h0, key_overflow}, 16'h0000);

`ifdef HACK_IO_KEY_FIFO_EN
        // Full FIFO: push and pop land on the same edge.
        for (int i = 0; i < 4; i++) press(8'(8'h51 + i));
        step(); keycode = 8'h55;
        step(); step(); key_strobe = 1'b1;
        step(); step(); bus(15'h6000, 1'b0, 16'h0, 1'b1);
        @(negedge clk); check("full_pop_head", io_rdata, 16'h0051);
        step(); bus(15'h6001, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        check("full_pushpop_status", io_rdata, 16'h0011);
        check("model_pushpop", exp_rdata(15'h6001), 16'h0011);
        repeat (3) step();
        key_strobe = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 5; i++) begin
            step(); bus(15'h6000, 1'b0, 16'h0, 1'b1);
            @(negedge clk);
            check("tail_order", io_rdata, (i < 4) ? 16'(16'h52 + i) : 16'h0000);
            step(); hack_clk_rise = 1'b0;
        end
        press(8'h00);
        addressM = 15'h6001;
        @(negedge clk);
        check("zero_key", io_rdata, 16'h0000);
`else
        // Level semantics: held key reads back on every poll, no pop.
        step(); keycode = 8'h20;
        step(); step(); key_strobe = 1'b1;
        repeat (4) step();
        for (int i = 0; i < 3; i++) begin
            bus(15'h6000, 1'b0, 16'h0, 1'b1);
            @(negedge clk); check("lvl_hold", io_rdata, 16'h0020);
            step();
        end
        bus(15'h6001, 1'b0, 16'h0, 1'b0);
        @(negedge clk); check("lvl_status_hi", io_rdata, 16'h0001);
        step(); key_strobe = 1'b0; addressM = 15'h6000;
        repeat (3) step();
        @(negedge clk); check("lvl_release", io_rdata, 16'h0000);
`endif

        // Random traffic against the model.
        ks_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            bus(15'(15'h5FFE + $urandom_range(0, 9)), 1'($urandom_range(0, 1)),
                16'($urandom), $urandom_range(0, 3) == 0);
            hack_reset = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 7) == 0) gpio_i = 16'($urandom);
            if (key_strobe) begin
                ks_cnt++;
                if (ks_cnt >= 3 && $urandom_range(0, 3) == 0) begin
                    key_strobe = 1'b0; ks_cnt = 0;
                end
            end else begin
                if (ks_cnt == 1)
                    keycode = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                ks_cnt++;
                if (ks_cnt >= 4 && $urandom_range(0, 2) == 0) begin
                    key_strobe = 1'b1; ks_cnt = 0;
                end
            end
        end
        step();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
